instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch front-end that consumes the program counter's NPC and drives the PC module's PC/ENABLE inputs. It issues reads to the synchronous instruction memory, which has 1-cycle read latency. Returned words are buffered in a 2-entry output queue with backpressure toward decode. Taken branches are applied as a redirect that squashes the in-flight read and flushes the queue.

Parameters:
IM_LENGTH, 9, instruction-memory address width; must equal `IM_Length
INSTR_WIDTH, 32, instruction word width

Ports:
CLK  input  1  clock
RESET  input  1  synchronous, active-high reset
ENABLE  input  1  run request; low stops new fetches but does not discard buffered or in-flight data
NPC  input  IM_LENGTH  next sequential address from the PC module
PC_OUT  output  IM_LENGTH  current fetch address, to the PC module's PC input
PC_EN  output  1  to the PC module's ENABLE; equals IM_EN
IM_ADDR  output  IM_LENGTH  instruction memory address; equals PC_OUT
IM_EN  output  1  memory read strobe (issue)
IM_DATA  input  INSTR_WIDTH  memory read data, valid 1 cycle after IM_EN
BRANCH_TAKEN  input  1  single-cycle redirect pulse
BRANCH_TARGET  input  IM_LENGTH  redirect address
STALL  input  1  decode not ready
INSTR  output  INSTR_WIDTH  head-of-queue instruction
INSTR_PC  output  IM_LENGTH  address of INSTR
INSTR_VALID  output  1  queue non-empty

Behaviour:
- Reset: RESET, synchronous and active-high, on CLK. State = IDLE; queue count = 0; inflight = 0; pend_valid = 0. INSTR_VALID, IM_EN, PC_EN = 0; INSTR, INSTR_PC = 0. RESET mid-operation drops all queued, in-flight and pending data; IM_DATA returning the next cycle is ignored.
- FSM:
  - IDLE -> RUN when ENABLE = 1.
  - RUN -> IDLE when ENABLE = 0.
  - No other states. Issue occurs only in RUN.
- Fetch address: FA = BRANCH_TAKEN ? BRANCH_TARGET : (pend_valid ? pend_target : NPC). PC_OUT = IM_ADDR = FA.
- pop = INSTR_VALID & ~STALL.
- Issue condition: IM_EN = (state == RUN) & (BRANCH_TAKEN | (count + inflight - pop < 2)).
  - On issue, the PC module latches FA+1, so NPC is correct on the next cycle.
  - Issue clears pend_valid.
  - Address wrap from 2^IM_LENGTH-1 to 0 is natural modulo arithmetic; no special handling.
- Response: inflight <= IM_EN. When inflight = 1 and not squashed, IM_DATA and its registered address are pushed to the queue tail in the same cycle IM_DATA is valid.
- Throughput: with STALL = 0, one instruction per cycle. First INSTR_VALID appears 2 cycles after the first issue: issue in cycle n, data in n+1, registered at the queue head in n+2.
- Queue:
  - 2-entry FIFO; INSTR/INSTR_PC always reflect the head.
  - Push and pop in the same cycle are both allowed.
  - The credit rule guarantees a push is never attempted when the queue is full.
- Branch (BRANCH_TAKEN = 1):
  - Flush the queue (count <= 0) and squash the in-flight response.
  - Branch has priority over pop, push and STALL in the same cycle.
  - In RUN: issue BRANCH_TARGET in the same cycle.
  - In IDLE: pend_target <= BRANCH_TARGET, pend_valid <= 1; the pending target is used at the next issue.
  - A branch in the cycle after a branch flushes the first target's response.
- STALL held: the head is stable. Issue stops once count + inflight reaches 2. No data is lost or duplicated.

Decomposition:
- IM_LENGTH and INSTR_WIDTH defaults, plus the IDLE/RUN state encodings, go in the shared parameters.v defines.
- One sub-module, fetch_queue: 2-entry FIFO of {addr, instr} with push, pop, flush, count outputs.

Test Plan:
1. Reset, ENABLE = 1, STALL = 0, IM[i] = 0xA000_0000 + i -> IM_ADDR = 0,1,2,… one per cycle; INSTR_VALID first high 2 cycles after the first issue, with INSTR_PC = 0, INSTR = 0xA000_0000; then consecutive values every cycle.
2. STALL = 1 for 5 cycles while streaming -> INSTR/INSTR_PC frozen; IM_EN low after ≤2 outstanding; on release, the sequence continues with no gap or duplicate.
3. BRANCH_TAKEN with target 0x40 while count = 2, inflight = 1, STALL = 1 -> next cycle count = 0; IM_ADDR = 0x40 in the branch cycle; INSTR_VALID shows PC 0x40 two cycles later; old addresses never appear.
4. ENABLE = 0 with a branch to 0x10 in IDLE, then ENABLE = 1 -> first issued address is 0x10, then 0x11.
5. Branch to 2^IM_LENGTH-2 = 510 -> delivered PCs are 510, 511, 0, 1.
6. RESET asserted for 1 cycle mid-stream with count = 2 -> next cycle INSTR_VALID = 0, IM_EN = 0; after ENABLE, fetch restarts at address 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch front-end.
package instr_fetch_unit_pkg;

  // Default widths; IM_LENGTH_DEF must track the instruction memory depth.
  localparam int unsigned IM_LENGTH_DEF   = 9;
  localparam int unsigned INSTR_WIDTH_DEF = 32;

  // Output queue geometry.
  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned CNT_W       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: 2-entry FIFO of {addr, instr} pairs; entry 0 is always the head.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   push, push_addr,    write a new entry at the tail
//   push_instr
//   pop                 drop the head entry
//   flush               empty the queue (wins over push/pop)
//   head_addr,          head entry contents (registered)
//   head_instr
//   count, valid        occupancy and non-empty flag
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned AW = IM_LENGTH_DEF,
  parameter int unsigned DW = INSTR_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic [AW-1:0]    push_addr,
  input  logic [DW-1:0]    push_instr,
  input  logic             pop,
  input  logic             flush,
  output logic [AW-1:0]    head_addr,
  output logic [DW-1:0]    head_instr,
  output logic [CNT_W-1:0] count,
  output logic             valid
);

  logic [AW-1:0]    addr0, addr1;
  logic [DW-1:0]    instr0, instr1;
  logic [CNT_W-1:0] cnt;
  logic             pop_ok;
  logic             push_ok;

  // Ignore pops on empty and pushes that would overflow.
  assign pop_ok  = pop & (cnt != '0);
  assign push_ok = push & ((cnt != CNT_W'(QUEUE_DEPTH)) | pop_ok);

  // Storage and occupancy; the head shifts forward on pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt    <= '0;
      addr0  <= '0;
      addr1  <= '0;
      instr0 <= '0;
      instr1 <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == '0) begin
            addr0  <= push_addr;
            instr0 <= push_instr;
          end else begin
            addr1  <= push_addr;
            instr1 <= push_instr;
          end
          cnt <= cnt + CNT_W'(1);
        end
        2'b01: begin
          addr0  <= addr1;
          instr0 <= instr1;
          cnt    <= cnt - CNT_W'(1);
        end
        2'b11: begin
          if (cnt == CNT_W'(QUEUE_DEPTH)) begin
            addr0  <= addr1;
            instr0 <= instr1;
            addr1  <= push_addr;
            instr1 <= push_instr;
          end else begin
            addr0  <= push_addr;
            instr0 <= push_instr;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_addr  = addr0;
  assign head_instr = instr0;
  assign count      = cnt;
  assign valid      = (cnt != '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front-end between the PC module, a 1-cycle-latency
// instruction memory and decode.
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   ENABLE                      run request
//   NPC                         next sequential address from the PC module
//   PC_OUT, PC_EN               fetch address / latch strobe to the PC module
//   IM_ADDR, IM_EN, IM_DATA     instruction memory read port
//   BRANCH_TAKEN, BRANCH_TARGET single-cycle redirect
//   STALL                       decode not ready
//   INSTR, INSTR_PC,            head of the output queue
//   INSTR_VALID
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned IM_LENGTH   = IM_LENGTH_DEF,
  parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic [IM_LENGTH-1:0]   NPC,
  output logic [IM_LENGTH-1:0]   PC_OUT,
  output logic                   PC_EN,
  output logic [IM_LENGTH-1:0]   IM_ADDR,
  output logic                   IM_EN,
  input  logic [INSTR_WIDTH-1:0] IM_DATA,
  input  logic                   BRANCH_TAKEN,
  input  logic [IM_LENGTH-1:0]   BRANCH_TARGET,
  input  logic                   STALL,
  output logic [INSTR_WIDTH-1:0] INSTR,
  output logic [IM_LENGTH-1:0]   INSTR_PC,
  output logic                   INSTR_VALID
);

  fetch_state_t           state, state_nxt;
  logic [IM_LENGTH-1:0]   fetch_addr;
  logic [IM_LENGTH-1:0]   inflight_addr;
  logic [IM_LENGTH-1:0]   pend_target;
  logic                   pend_valid;
  logic                   inflight;
  logic                   issue;
  logic                   credit_ok;
  logic                   pop;
  logic                   push;
  logic [CNT_W-1:0]       q_count;

  assign pop  = INSTR_VALID & ~STALL;
  // A redirect squashes the response arriving this cycle.
  assign push = inflight & ~BRANCH_TAKEN;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, fetch address and issue decision.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    fetch_addr = NPC;
    if (pend_valid)   fetch_addr = pend_target;
    if (BRANCH_TAKEN) fetch_addr = BRANCH_TARGET;
    // Queued + in-flight words, net of this cycle's pop, must leave a free slot.
    credit_ok = (3'(q_count) + 3'(inflight)) < (3'(QUEUE_DEPTH) + 3'(pop));
    case (state)
      IDLE: begin
        if (ENABLE) state_nxt = RUN;
      end
      RUN: begin
        issue = ~RESET & (BRANCH_TAKEN | credit_ok);
        if (!ENABLE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In-flight tracking and redirect held over while idle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
      pend_valid    <= 1'b0;
      pend_target   <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_addr <= fetch_addr;
      if (issue) begin
        pend_valid <= 1'b0;
      end else if (BRANCH_TAKEN && (state == IDLE)) begin
        pend_valid  <= 1'b1;
        pend_target <= BRANCH_TARGET;
      end
    end
  end

  fetch_queue #(
    .AW (IM_LENGTH),
    .DW (INSTR_WIDTH)
  ) u_queue (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (push),
    .push_addr  (inflight_addr),
    .push_instr (IM_DATA),
    .pop        (pop),
    .flush      (BRANCH_TAKEN),
    .head_addr  (INSTR_PC),
    .head_instr (INSTR),
    .count      (q_count),
    .valid      (INSTR_VALID)
  );

  assign PC_OUT  = fetch_addr;
  assign IM_ADDR = fetch_addr;
  assign IM_EN   = issue;
  assign PC_EN   = issue;

endmodule
